coef_sender: RTL and testbench

Transmit side of the serial coefficient-load interface. It snapshots a table of N_COEF coefficients on a start request and emits them one word at a time. Each word is framed by an enable level, a preceding clear pulse and a per-word change strobe, which is what the FIR coefficient bank expects. It sits between the control/UART command logic and the coefficient bank.

---
 rtl/coef_if_pkg.sv | 25 ++
 rtl/coef_shadow_reg.sv | 40 ++++
 rtl/coef_sender.sv | 180 ++++++++++++++++++
 tb/tb_coef_sender.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coef_if_pkg.sv
// coef_if_pkg: definitions shared by the coefficient-load transmit path.
//   state_t       - coef_sender FSM states (S_IDLE..S_DONE)
//   N_COEF_DEF    - default number of coefficients per transfer
//   COEF_W_DEF    - default coefficient width
//   word_period() - cycles spent per word (setup + strobe + hold)
package coef_if_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int unsigned N_COEF_DEF = 16;
    localparam int unsigned COEF_W_DEF = 12;

    function automatic int unsigned word_period(input int unsigned stb_len,
                                                input int unsigned gap_len);
        return 1 + stb_len + gap_len;
    endfunction

endpackage

// File: rtl/coef_shadow_reg.sv
// coef_shadow_reg: snapshot of the coefficient table with an indexed read.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (table cleared)
//   i_load         : capture i_coefs into the table
//   i_coefs        : flat table, coef k at [k*COEF_W +: COEF_W]
//   i_idx          : read index (out-of-range reads return 0)
//   o_data         : table[i_idx], combinational from the registered table
module coef_shadow_reg
    import coef_if_pkg::*;
#(
    parameter int unsigned N_COEF = N_COEF_DEF,
    parameter int unsigned COEF_W = COEF_W_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_load,
    input  logic [N_COEF*COEF_W-1:0]   i_coefs,
    input  logic [5:0]                 i_idx,
    output logic [COEF_W-1:0]          o_data
);

    logic [N_COEF*COEF_W-1:0] r_tbl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tbl <= '0;
        end else if (i_load) begin
            r_tbl <= i_coefs;
        end
    end

    always_comb begin
        o_data = '0;
        for (int unsigned k = 0; k < N_COEF; k++) begin
            if (i_idx == 6'(k)) begin
                o_data = r_tbl[k*COEF_W +: COEF_W];
            end
        end
    end

endmodule

// File: rtl/coef_sender.sv
// coef_sender: transmit side of the serial coefficient-load interface.
// Snapshots N_COEF coefficients on start_i and sends them one word at a
// time: clear pulse, then per word SETUP (data valid), STROBE (STB_LEN
// cycles of cambio_coef_o) and HOLD (GAP_LEN cycles), then a done pulse.
//   clk, rst_n             : clock, asynchronous active-low reset
//   start_i                : start a transfer (IDLE only)
//   abort_i                : cancel a transfer, back to IDLE with outputs 0
//   coefs_i                : coefficient table, coef k at [k*COEF_W +: COEF_W]
//   coef_o                 : current coefficient word
//   cambio_coef_o          : per-word change strobe
//   en_recepcion_o         : high during the word phase
//   pulsador_carga_coef_o  : one-cycle clear pulse at transfer start
//   busy_o                 : high outside IDLE
//   done_o                 : one-cycle completion pulse
//   cksum_o                : (COEF_SENDER_CKSUM_EN only) 16-bit running sum of
//                            the words sent, cleared at transfer start
// Optional feature macro: COEF_SENDER_CKSUM_EN.
module coef_sender
    import coef_if_pkg::*;
#(
    parameter int unsigned N_COEF  = N_COEF_DEF,
    parameter int unsigned COEF_W  = COEF_W_DEF,
    parameter int unsigned STB_LEN = 2,
    parameter int unsigned GAP_LEN = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [N_COEF*COEF_W-1:0]   coefs_i,
    output logic [COEF_W-1:0]          coef_o,
    output logic                       cambio_coef_o,
    output logic                       en_recepcion_o,
    output logic                       pulsador_carga_coef_o,
    output logic                       busy_o,
    output logic                       done_o
`ifdef COEF_SENDER_CKSUM_EN
    ,
    output logic [15:0]                cksum_o
`endif
);

    localparam int unsigned MAX_LEN = (STB_LEN > GAP_LEN) ? STB_LEN : GAP_LEN;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t              r_state;
    logic [5:0]          r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [COEF_W-1:0]   r_coef;
    logic                r_stb;
    logic                r_en;
    logic                r_clr;
    logic                r_busy;
    logic                r_done;
`ifdef COEF_SENDER_CKSUM_EN
    logic [15:0]         r_cksum;
`endif

    logic                w_load;
    logic [5:0]          w_rd_idx;
    logic [COEF_W-1:0]   w_rd_data;

    assign w_load = (r_state == S_IDLE) && start_i && !abort_i;
    // HOLD loads the next word on its final edge, so look one index ahead.
    assign w_rd_idx = (r_state == S_HOLD) ? (r_idx + 6'd1) : r_idx;

    coef_shadow_reg #(
        .N_COEF (N_COEF),
        .COEF_W (COEF_W)
    ) u_shadow (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_load  (w_load),
        .i_coefs (coefs_i),
        .i_idx   (w_rd_idx),
        .o_data  (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_coef  <= '0;
            r_stb   <= 1'b0;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef COEF_SENDER_CKSUM_EN
            r_cksum <= '0;
`endif
        end else if ((r_state != S_IDLE) && abort_i) begin
            // Checksum deliberately keeps its partial value on abort.
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_coef  <= '0;
            r_stb   <= 1'b0;
            r_en    <= 1'b0;
            r_clr   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_load) begin
                        r_state <= S_CLEAR;
                        r_idx   <= '0;
                        r_clr   <= 1'b1;
                        r_busy  <= 1'b1;
`ifdef COEF_SENDER_CKSUM_EN
                        r_cksum <= '0;
`endif
                    end
                end
                S_CLEAR: begin
                    r_state <= S_SETUP;
                    r_clr   <= 1'b0;
                    r_coef  <= w_rd_data;
                    r_en    <= 1'b1;
                end
                S_SETUP: begin
                    r_state <= S_STROBE;
                    r_stb   <= 1'b1;
                    r_cnt   <= '0;
`ifdef COEF_SENDER_CKSUM_EN
                    r_cksum <= r_cksum + 16'(r_coef);
`endif
                end
                S_STROBE: begin
                    if (r_cnt == CNT_W'(STB_LEN - 1)) begin
                        r_state <= S_HOLD;
                        r_stb   <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == CNT_W'(GAP_LEN - 1)) begin
                        r_cnt <= '0;
                        if (r_idx < 6'(N_COEF - 1)) begin
                            r_idx   <= r_idx + 6'd1;
                            r_coef  <= w_rd_data;
                            r_state <= S_SETUP;
                        end else begin
                            r_state <= S_DONE;
                            r_coef  <= '0;
                            r_en    <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign coef_o                = r_coef;
    assign cambio_coef_o         = r_stb;
    assign en_recepcion_o        = r_en;
    assign pulsador_carga_coef_o = r_clr;
    assign busy_o                = r_busy;
    assign done_o                = r_done;
`ifdef COEF_SENDER_CKSUM_EN
    assign cksum_o               = r_cksum;
`endif

endmodule

// File: tb/tb_coef_sender.sv
// tb_coef_sender: self-checking bench for coef_sender. A transfer-level model
// (offset from the start edge -> expected outputs) is compared every cycle,
// plus directed literal checks on latency, strobe count, abort and reset.
module tb_coef_sender;

    localparam int unsigned N   = 16;
    localparam int unsigned W   = 12;
    localparam int unsigned STB = 2;
    localparam int unsigned GAP = 2;
    localparam int unsigned P   = 1 + STB + GAP;
    localparam int unsigned D   = 2 + N * P;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [N*W-1:0]   coefs_i = '0;
    logic [W-1:0]     coef_o;
    logic             cambio_coef_o;
    logic             en_recepcion_o;
    logic             pulsador_carga_coef_o;
    logic             busy_o;
    logic             done_o;
`ifdef COEF_SENDER_CKSUM_EN
    logic [15:0]      cksum_o;
`endif

    coef_sender #(
        .N_COEF  (N),
        .COEF_W  (W),
        .STB_LEN (STB),
        .GAP_LEN (GAP)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start_i               (start_i),
        .abort_i               (abort_i),
        .coefs_i               (coefs_i),
        .coef_o                (coef_o),
        .cambio_coef_o         (cambio_coef_o),
        .en_recepcion_o        (en_recepcion_o),
        .pulsador_carga_coef_o (pulsador_carga_coef_o),
        .busy_o                (busy_o),
        .done_o                (done_o)
`ifdef COEF_SENDER_CKSUM_EN
        ,
        .cksum_o               (cksum_o)
`endif
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    bit          chk_en = 1'b0;
    int unsigned stb_cnt = 0;
    logic        prev_stb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Transfer-level model: m_t is the cycle number since the start edge.
    bit           m_act = 1'b0;
    int unsigned  m_t = 0;
    logic [W-1:0] m_snap [N];
    logic [15:0]  m_ck = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 1'b0;
            m_t   = 0;
            m_ck  = '0;
        end else begin
            if (m_act) begin
                if (abort_i) begin
                    m_act = 1'b0;
                end else begin
                    m_t++;
                    if (m_t > D) m_act = 1'b0;
                end
            end else if (start_i && !abort_i) begin
                m_act = 1'b1;
                m_t   = 1;
                m_ck  = '0;
                for (int k = 0; k < N; k++) m_snap[k] = coefs_i[k*W +: W];
            end
            if (m_act && m_t >= 2 && m_t <= 1 + N * P && (m_t - 2) % P == 1)
                m_ck = m_ck + 16'(m_snap[(m_t - 2) / P]);
        end
    end

    logic [W-1:0] e_coef;
    logic         e_stb, e_en, e_clr, e_busy, e_done;
    int unsigned  e_ph;

    always @(negedge clk) begin
        if (chk_en) begin
            e_coef = '0;
            e_stb  = 1'b0;
            e_en   = 1'b0;
            e_clr  = m_act && (m_t == 1);
            e_busy = m_act;
            e_done = m_act && (m_t == D);
            if (m_act && m_t >= 2 && m_t <= 1 + N * P) begin
                e_ph   = (m_t - 2) % P;
                e_en   = 1'b1;
                e_coef = m_snap[(m_t - 2) / P];
                e_stb  = (e_ph >= 1) && (e_ph <= STB);
            end
            chk("coef_o", 32'(coef_o), 32'(e_coef));
            chk("cambio_coef_o", 32'(cambio_coef_o), 32'(e_stb));
            chk("en_recepcion_o", 32'(en_recepcion_o), 32'(e_en));
            chk("pulsador_carga_coef_o", 32'(pulsador_carga_coef_o), 32'(e_clr));
            chk("busy_o", 32'(busy_o), 32'(e_busy));
            chk("done_o", 32'(done_o), 32'(e_done));
`ifdef COEF_SENDER_CKSUM_EN
            chk("cksum_o", 32'(cksum_o), 32'(m_ck));
`endif
        end
        if (cambio_coef_o && !prev_stb) stb_cnt++;
        prev_stb = cambio_coef_o;
    end

    // Pulse start_i for one edge; returns 2 time units into cycle 1.
    task automatic start_pulse();
        @(posedge clk); #2;
        start_i = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
    endtask

    // Called from cycle 1; reports the cycle number of done_o (0 on timeout).
    task automatic wait_done(output int unsigned dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = 0;
        for (int unsigned i = 1; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                dcyc = i;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    int unsigned dc;
    int unsigned ab_at;
    bit          do_ab;

    initial begin
        // Reset for 3 cycles then 20 idle cycles.
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_coef", 32'(coef_o), 32'd0);

        // Full transfer with 0x100+k, snapshot overwrite, start while busy.
        for (int k = 0; k < N; k++) coefs_i[k*W +: W] = W'(12'h100 + k);
        stb_cnt = 0;
        start_pulse();
        coefs_i = '1;
        fork
            wait_done(dc);
            begin
                @(negedge clk);
                chk("clear_pulse_cycle1", 32'(pulsador_carga_coef_o), 32'd1);
                repeat (18) @(posedge clk);
                @(negedge clk);
                chk("word3_coef", 32'(coef_o), 32'h103);
                chk("word3_strobe", 32'(cambio_coef_o), 32'd1);
                repeat (11) @(posedge clk);
                #2 start_i = 1'b1;
                @(posedge clk);
                #2 start_i = 1'b0;
            end
        join
        chk("done_cycle", dc, 32'd82);
        chk("strobe_count", stb_cnt, 32'd16);
        repeat (5) @(posedge clk);

        // Abort at cycle 40.
        for (int k = 0; k < N; k++) coefs_i[k*W +: W] = W'($urandom);
        start_pulse();
        repeat (39) @(posedge clk);
        #2 abort_i = 1'b1;
        @(posedge clk);
        #2 abort_i = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_en", 32'(en_recepcion_o), 32'd0);
        chk("abort_coef", 32'(coef_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        repeat (50) @(posedge clk);

        // New transfer after abort runs to completion.
        stb_cnt = 0;
        start_pulse();
        wait_done(dc);
        chk("post_abort_done_cycle", dc, 32'd82);
        chk("post_abort_strobes", stb_cnt, 32'd16);
        repeat (3) @(posedge clk);

        // start_i and abort_i together in IDLE: no transfer.
        #2 start_i = 1'b1; abort_i = 1'b1;
        @(posedge clk);
        #2 start_i = 1'b0; abort_i = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", 32'(busy_o), 32'd0);

        // Randomised traffic: random tables every cycle, random starts/aborts.
        for (int r = 0; r < 6; r++) begin
            do_ab = ($urandom_range(0, 1) == 1);
            ab_at = $urandom_range(2, 95);
            for (int unsigned c = 0; c < 110; c++) begin
                @(posedge clk); #2;
                for (int k = 0; k < N; k++) coefs_i[k*W +: W] = W'($urandom);
                start_i = (c == 0) || ($urandom_range(0, 15) == 0);
                abort_i = do_ab && (c == ab_at);
            end
            #0 start_i = 1'b0;
            abort_i = 1'b0;
            repeat (100) @(posedge clk);
        end

`ifdef COEF_SENDER_CKSUM_EN
        coefs_i = '1;
        start_pulse();
        wait_done(dc);
        chk("cksum_at_done", 32'(cksum_o), 32'h0000fff0);
        repeat (3) @(posedge clk);
`endif

        // Asynchronous reset mid-transfer (inside a strobe).
        for (int k = 0; k < N; k++) coefs_i[k*W +: W] = W'($urandom_range(1, 4095));
        start_pulse();
        repeat (22) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_coef", 32'(coef_o), 32'd0);
        chk("rst_strobe", 32'(cambio_coef_o), 32'd0);
        chk("rst_en", 32'(en_recepcion_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
`ifdef COEF_SENDER_CKSUM_EN
        chk("rst_cksum", 32'(cksum_o), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
